// File: rtl/spill_fifo_pkg.sv
// Shared types for the flushable spill FIFO: drop-counter width, its type and a saturating adder.
package spill_fifo_pkg;

  localparam int DropCntWidth = 16;

  typedef logic [DropCntWidth-1:0] drop_cnt_t;
  typedef logic [DropCntWidth:0]   drop_inc_t;

  function automatic drop_cnt_t drop_sat_add(input drop_cnt_t acc, input drop_inc_t inc);
    logic [DropCntWidth+1:0] sum;
    sum = {2'b00, acc} + {1'b0, inc};
    if (sum > {2'b00, {DropCntWidth{1'b1}}}) begin
      return {DropCntWidth{1'b1}};
    end
    return sum[DropCntWidth-1:0];
  endfunction

endpackage

// File: rtl/spill_fifo_ptr_cnt.sv
// Circular-buffer pointer: advances on inc, wraps Depth-1 -> 0 (any Depth), clr wins over inc.
// One-cycle update latency; no flow control of its own.
module spill_fifo_ptr_cnt #(
  parameter int Depth = 2,
  localparam int PtrW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clr,
  output logic [PtrW-1:0] ptr
);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr_q;
    if (clr) begin
      ptr_nxt = '0;
    end else if (inc) begin
      ptr_nxt = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/spill_fifo_flushable.sv
// Registered-output FIFO with flush; 1-cycle latency, ready_o drops only when full. Bypass=1 makes it a wire.
// SPILL_FIFO_DROP_CNT_EN enables the flush drop counter; SPILL_FIFO_ASSERTS_OFF removes the protocol checks.
module spill_fifo_flushable
  import spill_fifo_pkg::*;
#(
  parameter int Width  = 8,
  parameter int Depth  = 2,
  parameter int Bypass = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [Width-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output drop_cnt_t                  drop_cnt_o
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = $clog2(Depth);

  generate
    if (Bypass != 0) begin : g_bypass
      assign valid_o    = valid_i;
      assign ready_o    = ready_i;
      assign data_o     = data_i;
      assign usage_o    = '0;
      assign drop_cnt_o = '0;
    end else begin : g_fifo
      logic [Width-1:0] mem_q [Depth];
      logic [Width-1:0] last_q;
      logic [CntW-1:0]  usage_q;
      logic [PtrW-1:0]  rd_ptr;
      logic [PtrW-1:0]  wr_ptr;
      logic             push;
      logic             pop;

      // Flags come from the occupancy register only, so no input reaches an output.
      assign ready_o = (usage_q < CntW'(Depth));
      assign valid_o = (usage_q != '0);
      assign push    = valid_i && ready_o;
      assign pop     = valid_o && ready_i;

      spill_fifo_ptr_cnt #(.Depth(Depth)) u_rd_ptr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (pop),
        .clr   (flush_i),
        .ptr   (rd_ptr)
      );

      spill_fifo_ptr_cnt #(.Depth(Depth)) u_wr_ptr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (push),
        .clr   (flush_i),
        .ptr   (wr_ptr)
      );

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
          end
        end else if (push && !flush_i) begin
          mem_q[wr_ptr] <= data_i;
        end
      end

      // Holds the most recently popped word so data_o stays stable while empty.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          last_q <= '0;
        end else if (pop) begin
          last_q <= mem_q[rd_ptr];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          usage_q <= '0;
        end else if (flush_i) begin
          usage_q <= '0;
        end else if (push && !pop) begin
          usage_q <= usage_q + CntW'(1);
        end else if (pop && !push) begin
          usage_q <= usage_q - CntW'(1);
        end
      end

      assign data_o  = valid_o ? mem_q[rd_ptr] : last_q;
      assign usage_o = usage_q;

`ifdef SPILL_FIFO_DROP_CNT_EN
      drop_cnt_t drop_q;
      drop_inc_t drop_inc;

      // Entries lost to a flush: what was held, minus the one leaving, plus the one refused.
      assign drop_inc = drop_inc_t'(usage_q) + drop_inc_t'(push) - drop_inc_t'(pop);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          drop_q <= '0;
        end else if (flush_i) begin
          drop_q <= drop_sat_add(drop_q, drop_inc);
        end
      end

      assign drop_cnt_o = drop_q;
`else
      assign drop_cnt_o = '0;
`endif

`ifndef SPILL_FIFO_ASSERTS_OFF
      a_flush_no_push : assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i |-> !valid_i);
      a_full_no_push : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (usage_q == CntW'(Depth)) |-> !push);
      a_usage_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        usage_q <= CntW'(Depth));
`endif
    end
  endgenerate

endmodule

// File: tb/tb_spill_fifo_flushable.sv
// Bench for spill_fifo_flushable (Width=8, Depth=4): vector table, corner sequences, random vs queue model, bypass.
module tb_spill_fifo_flushable;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_in;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] data_out;
  logic [2:0] usage;
  logic [15:0] drop_cnt;

  logic       b_flush;
  logic       b_valid_in;
  logic       b_ready_out;
  logic [7:0] b_data_in;
  logic       b_valid_out;
  logic       b_ready_in;
  logic [7:0] b_data_out;
  logic [2:0] b_usage;
  logic [15:0] b_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_last;
  int         m_drop;

  spill_fifo_flushable #(.Width(8), .Depth(4), .Bypass(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid_in), .ready_o(ready_out), .data_i(data_in),
    .valid_o(valid_out), .ready_i(ready_in), .data_o(data_out),
    .usage_o(usage), .drop_cnt_o(drop_cnt)
  );

  spill_fifo_flushable #(.Width(8), .Depth(4), .Bypass(1)) dut_byp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .valid_i(b_valid_in), .ready_o(b_ready_out), .data_i(b_data_in),
    .valid_o(b_valid_out), .ready_i(b_ready_in), .data_o(b_data_out),
    .usage_o(b_usage), .drop_cnt_o(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef SPILL_FIFO_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_drop = 0;
  endtask

  // Queue-level reference: a pop takes the head, a flush throws the rest away.
  task automatic model_step(input logic v, input logic r, input logic f, input logic [7:0] d);
    bit do_push;
    bit do_pop;
    do_push = v && (mq.size() < 4);
    do_pop  = r && (mq.size() != 0);
    if (do_pop) m_last = mq.pop_front();
    if (f) begin
      m_drop = m_drop + mq.size() + int'(do_push);
      if (m_drop > 65535) m_drop = 65535;
      mq.delete();
    end else if (do_push) begin
      mq.push_back(d);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, ".valid"}, valid_out, mq.size() != 0);
    check({tag, ".ready"}, ready_out, mq.size() < 4);
    check({tag, ".usage"}, usage, mq.size());
    check({tag, ".data"}, data_out, (mq.size() != 0) ? mq[0] : m_last);
    check({tag, ".drop"}, drop_cnt, exp_drop());
  endtask

  task automatic step(input logic v, input logic r, input logic f, input logic [7:0] d);
    valid_in = v;
    ready_in = r;
    flush    = f;
    data_in  = d;
    model_step(v, r, f, d);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] d;
    logic [2:0] usage;
    logic       valid;
    logic       ready;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int popped;
    logic [7:0] exp_next;

    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = 8'h00;
    b_flush = 1'b0; b_valid_in = 1'b0; b_ready_in = 1'b0; b_data_in = 8'h00;
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 8'hA1, 3'd1, 1'b1, 1'b1, 8'hA1};
    tbl[1] = '{1'b1, 1'b0, 8'hA2, 3'd2, 1'b1, 1'b1, 8'hA1};
    tbl[2] = '{1'b1, 1'b0, 8'hA3, 3'd3, 1'b1, 1'b1, 8'hA1};
    tbl[3] = '{1'b1, 1'b0, 8'hA4, 3'd4, 1'b1, 1'b0, 8'hA1};
    tbl[4] = '{1'b1, 1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 8'hA1};
    tbl[5] = '{1'b1, 1'b1, 8'hA5, 3'd3, 1'b1, 1'b1, 8'hA2};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b1, 8'hA3};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 3'd1, 1'b1, 1'b1, 8'hA4};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 8'hA4};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 8'hA4};

    #12;
    check("rst.valid", valid_out, 1'b0);
    check("rst.ready", ready_out, 1'b1);
    check("rst.usage", usage, 3'd0);
    check("rst.data", data_out, 8'h00);
    check("rst.drop", drop_cnt, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].r, 1'b0, tbl[i].d);
      check($sformatf("vec%0d.usage", i), usage, tbl[i].usage);
      check($sformatf("vec%0d.valid", i), valid_out, tbl[i].valid);
      check($sformatf("vec%0d.ready", i), ready_out, tbl[i].ready);
      check($sformatf("vec%0d.data", i), data_out, tbl[i].data);
    end

    // Continuous streaming: one item per cycle, in order.
    popped = 0;
    exp_next = 8'h00;
    for (int i = 0; i < 100; i++) begin
      if (valid_out) begin
        check("stream.data", data_out, exp_next);
        exp_next++;
        popped++;
      end
      step(1'b1, 1'b1, 1'b0, 8'(i));
      if (i > 0) check("stream.usage", usage, 3'd1);
    end
    if (valid_out) begin
      check("stream.data", data_out, exp_next);
      popped++;
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("stream.count", popped, 100);
    model_check("stream_end");

    // Flush with three held; the head still leaves on the flush edge.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 1'b0, 8'hB3);
    check("flush.pre_valid", valid_out, 1'b1);
    check("flush.pre_data", data_out, 8'hB1);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("flush.usage", usage, 3'd0);
    check("flush.valid", valid_out, 1'b0);
    check("flush.data", data_out, 8'hB1);
`ifdef SPILL_FIFO_DROP_CNT_EN
    check("flush.drop", drop_cnt, 16'd2);
`else
    check("flush.drop", drop_cnt, 16'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 8'hC1);
    model_check("post_flush");

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 1'b0, 1'b0, 8'hD2);
    check("arst.pre_usage", usage, 3'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.valid", valid_out, 1'b0);
    check("arst.usage", usage, 3'd0);
    check("arst.data", data_out, 8'h00);
    check("arst.ready", ready_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_check("arst_after");

    // Random traffic with alternating drain pressure.
    for (int i = 0; i < 2000; i++) begin
      logic f;
      logic v;
      logic r;
      f = ($urandom_range(0, 24) == 0);
      v = f ? 1'b0 : 1'($urandom_range(0, 1));
      r = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(v, r, f, 8'($urandom));
      model_check("rand");
    end

    // Bypass instance: pure wires, flush ignored.
    for (int i = 0; i < 16; i++) begin
      b_valid_in = 1'($urandom_range(0, 1));
      b_ready_in = 1'($urandom_range(0, 1));
      b_data_in  = 8'($urandom);
      b_flush    = 1'($urandom_range(0, 1));
      #1;
      check("byp.valid", b_valid_out, b_valid_in);
      check("byp.ready", b_ready_out, b_ready_in);
      check("byp.data", b_data_out, b_data_in);
      check("byp.usage", b_usage, 3'd0);
      check("byp.drop", b_drop_cnt, 16'd0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
